// File: rtl/game_controller.sv
// Frame-rate sequencer for the road-crossing game: moves the four car lanes once per frame,
// scans them against the player, and tracks lives, level and the game state.
module game_controller #(
    parameter int H_DISPLAY     = 640,
    parameter int V_DISPLAY     = 480,
    parameter int CAR_WIDTH     = 40,
    parameter int CAR_HEIGHT    = 30,
    parameter int PLAYER_WIDTH  = 20,
    parameter int PLAYER_HEIGHT = 20,
    parameter int CAR_Y1        = 100,
    parameter int CAR_Y2        = 160,
    parameter int CAR_Y3        = 220,
    parameter int CAR_Y4        = 280,
    parameter int GOAL_Y        = 40,
    parameter int LIVES_INIT    = 3,
    parameter int HIT_FRAMES    = 60
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic       start,
    output logic [9:0] car_x1,
    output logic [9:0] car_x2,
    output logic [9:0] car_x3,
    output logic [9:0] car_x4,
    output logic [1:0] game_state,
    output logic [1:0] lives,
    output logic [2:0] level,
    output logic       player_reset,
    output logic       frame_tick
);

    localparam int CW = $clog2(HIT_FRAMES + 1);
    localparam logic [9:0] INIT_X1 = 10'd0;
    localparam logic [9:0] INIT_X2 = 10'(H_DISPLAY / 4);
    localparam logic [9:0] INIT_X3 = 10'(H_DISPLAY / 2);
    localparam logic [9:0] INIT_X4 = 10'((H_DISPLAY / 4) * 3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        P_IDLE,
        P_WAIT,
        P_SCAN1,
        P_SCAN2,
        P_SCAN3,
        P_SCAN4,
        P_DECIDE
    } phase_t;

    state_t        r_state, w_state_next;
    phase_t        r_phase, w_phase_next;
    logic [9:0]    r_car_x1, r_car_x2, r_car_x3, r_car_x4;
    logic [1:0]    r_lives, w_lives_next;
    logic [2:0]    r_level, w_level_next;
    logic          r_player_reset, w_player_reset_next;
    logic          r_frame_tick;
    logic          r_hit, w_hit_next;
    logic [CW-1:0] r_hit_cnt, w_hit_cnt_next;
    logic          w_tick, w_move, w_load_init, w_overlap;
    logic [10:0]   w_speed_odd, w_speed_even, w_scan_y;
    logic [9:0]    w_scan_car;

    function automatic logic [9:0] moveRight(input logic [9:0] x, input logic [10:0] s);
        logic [10:0] sum;
        sum = {1'b0, x} + s;
        if (sum >= 11'(H_DISPLAY))
            return 10'(sum - 11'(H_DISPLAY));
        return 10'(sum);
    endfunction

    function automatic logic [9:0] moveLeft(input logic [9:0] x, input logic [10:0] s);
        if ({1'b0, x} < s)
            return 10'({1'b0, x} + 11'(H_DISPLAY) - s);
        return 10'({1'b0, x} - s);
    endfunction

    assign w_tick       = (h_count == 10'd0) && (v_count == 10'(V_DISPLAY));
    assign w_move       = w_tick && (r_state == S_PLAY);
    assign w_speed_odd  = 11'(r_level) + 11'd1;
    assign w_speed_even = 11'(r_level) + 11'd2;

    // Each scan cycle looks at one lane; the player position is sampled live.
    always_comb begin
        w_scan_car = r_car_x1;
        w_scan_y   = 11'(CAR_Y1);
        case (r_phase)
            P_SCAN2: begin w_scan_car = r_car_x2; w_scan_y = 11'(CAR_Y2); end
            P_SCAN3: begin w_scan_car = r_car_x3; w_scan_y = 11'(CAR_Y3); end
            P_SCAN4: begin w_scan_car = r_car_x4; w_scan_y = 11'(CAR_Y4); end
            default: ;
        endcase
    end

    assign w_overlap = ({1'b0, player_x} < {1'b0, w_scan_car} + 11'(CAR_WIDTH)) &&
                       ({1'b0, w_scan_car} < {1'b0, player_x} + 11'(PLAYER_WIDTH)) &&
                       ({1'b0, player_y} < w_scan_y + 11'(CAR_HEIGHT)) &&
                       (w_scan_y < {1'b0, player_y} + 11'(PLAYER_HEIGHT));

    always_comb begin
        w_state_next        = r_state;
        w_phase_next        = r_phase;
        w_lives_next        = r_lives;
        w_level_next        = r_level;
        w_player_reset_next = 1'b0;
        w_hit_next          = r_hit;
        w_hit_cnt_next      = r_hit_cnt;
        w_load_init         = 1'b0;

        case (r_state)
            S_IDLE: if (start) w_state_next = S_PLAY;
            S_HIT: begin
                if (w_tick) begin
                    if (r_hit_cnt == CW'(HIT_FRAMES - 1)) begin
                        w_state_next        = S_PLAY;
                        w_player_reset_next = 1'b1;
                        w_hit_cnt_next      = '0;
                    end else begin
                        w_hit_cnt_next = r_hit_cnt + CW'(1);
                    end
                end
            end
            S_OVER: begin
                if (start) begin
                    w_load_init         = 1'b1;
                    w_lives_next        = 2'(LIVES_INIT);
                    w_level_next        = 3'd0;
                    w_player_reset_next = 1'b1;
                    w_state_next        = S_PLAY;
                end
            end
            default: ;
        endcase

        // The scan waits one cycle so it sees the freshly moved cars.
        case (r_phase)
            P_IDLE:  if (w_move) w_phase_next = P_WAIT;
            P_WAIT:  w_phase_next = P_SCAN1;
            P_SCAN1: begin w_hit_next = r_hit | w_overlap; w_phase_next = P_SCAN2; end
            P_SCAN2: begin w_hit_next = r_hit | w_overlap; w_phase_next = P_SCAN3; end
            P_SCAN3: begin w_hit_next = r_hit | w_overlap; w_phase_next = P_SCAN4; end
            P_SCAN4: begin w_hit_next = r_hit | w_overlap; w_phase_next = P_DECIDE; end
            P_DECIDE: begin
                w_phase_next = P_IDLE;
                w_hit_next   = 1'b0;
                if (r_hit) begin
                    if (r_lives == 2'd1) begin
                        w_lives_next = 2'd0;
                        w_state_next = S_OVER;
                    end else if (r_lives > 2'd1) begin
                        w_lives_next   = r_lives - 2'd1;
                        w_state_next   = S_HIT;
                        w_hit_cnt_next = '0;
                    end
                end else if (player_y < 10'(GOAL_Y)) begin
                    if (r_level != 3'd7)
                        w_level_next = r_level + 3'd1;
                    w_player_reset_next = 1'b1;
                end
            end
            default: w_phase_next = P_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state        <= S_IDLE;
            r_phase        <= P_IDLE;
            r_car_x1       <= INIT_X1;
            r_car_x2       <= INIT_X2;
            r_car_x3       <= INIT_X3;
            r_car_x4       <= INIT_X4;
            r_lives        <= 2'(LIVES_INIT);
            r_level        <= 3'd0;
            r_player_reset <= 1'b0;
            r_frame_tick   <= 1'b0;
            r_hit          <= 1'b0;
            r_hit_cnt      <= '0;
        end else begin
            r_state        <= w_state_next;
            r_phase        <= w_phase_next;
            r_lives        <= w_lives_next;
            r_level        <= w_level_next;
            r_player_reset <= w_player_reset_next;
            r_frame_tick   <= w_tick;
            r_hit          <= w_hit_next;
            r_hit_cnt      <= w_hit_cnt_next;
            if (w_load_init) begin
                r_car_x1 <= INIT_X1;
                r_car_x2 <= INIT_X2;
                r_car_x3 <= INIT_X3;
                r_car_x4 <= INIT_X4;
            end else if (w_move) begin
                r_car_x1 <= moveRight(r_car_x1, w_speed_odd);
                r_car_x2 <= moveLeft(r_car_x2, w_speed_even);
                r_car_x3 <= moveRight(r_car_x3, w_speed_odd);
                r_car_x4 <= moveLeft(r_car_x4, w_speed_even);
            end
        end
    end

    assign car_x1       = r_car_x1;
    assign car_x2       = r_car_x2;
    assign car_x3       = r_car_x3;
    assign car_x4       = r_car_x4;
    assign game_state   = r_state;
    assign lives        = r_lives;
    assign level        = r_level;
    assign player_reset = r_player_reset;
    assign frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_game_controller.sv
// Frame-by-frame directed bench for game_controller using short 16-cycle frames.
// Lane 1 is moved up to row 20 so a goal-row player can also overlap a car.
module tb_game_controller;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [9:0] h_count, v_count, player_x, player_y;
    logic       start;
    logic [9:0] car_x1, car_x2, car_x3, car_x4;
    logic [1:0] game_state, lives;
    logic [2:0] level;
    logic       player_reset, frame_tick;

    game_controller #(.CAR_Y1(20)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .h_count      (h_count),
        .v_count      (v_count),
        .player_x     (player_x),
        .player_y     (player_y),
        .start        (start),
        .car_x1       (car_x1),
        .car_x2       (car_x2),
        .car_x3       (car_x3),
        .car_x4       (car_x4),
        .game_state   (game_state),
        .lives        (lives),
        .level        (level),
        .player_reset (player_reset),
        .frame_tick   (frame_tick)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int doStart;
        int reps;
        int px, py;
        int c1, c2, c3, c4;
        int st, li, lv;
        int ticks, resets;
    } vec_t;

    vec_t vecs[17];
    int   compared = 0;
    int   mismatched = 0;
    int   fTicks, fResets, fResetOff;
    int   mx[4];
    int   lvl;

    function automatic vec_t mk(input int doStart, input int reps, input int px, input int py,
                                input int c1, input int c2, input int c3, input int c4,
                                input int st, input int li, input int lv,
                                input int ticks, input int resets);
        vec_t v;
        v.doStart = doStart; v.reps = reps; v.px = px; v.py = py;
        v.c1 = c1; v.c2 = c2; v.c3 = c3; v.c4 = c4;
        v.st = st; v.li = li; v.lv = lv; v.ticks = ticks; v.resets = resets;
        return v;
    endfunction

    function automatic int wrapR(input int x, input int s);
        return (x + s) % 640;
    endfunction

    function automatic int wrapL(input int x, input int s);
        return ((x - s) % 640 + 640) % 640;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One frame: cycle 0 is the frame-tick detect cycle, outputs sampled at offsets 1..15.
    task automatic runFrame(input int px, input int py);
        @(posedge CLK); #1;
        h_count  = 10'd0;
        v_count  = 10'd480;
        player_x = 10'(px);
        player_y = 10'(py);
        for (int c = 1; c < 16; c++) begin
            @(posedge CLK); #1;
            h_count = 10'd5;
            v_count = 10'd0;
            if (frame_tick) fTicks++;
            if (player_reset) begin
                fResets++;
                fResetOff = c;
            end
        end
    endtask

    task automatic pulseStart();
        @(posedge CLK); #1;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        if (player_reset) fResets++;
        if (frame_tick) fTicks++;
    endtask

    task automatic checkCars(input string tag);
        checkOutput({tag, " car_x1"}, int'(car_x1), mx[0]);
        checkOutput({tag, " car_x2"}, int'(car_x2), mx[1]);
        checkOutput({tag, " car_x3"}, int'(car_x3), mx[2]);
        checkOutput({tag, " car_x4"}, int'(car_x4), mx[3]);
    endtask

    task automatic checkRow(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        mx[0] = v.c1; mx[1] = v.c2; mx[2] = v.c3; mx[3] = v.c4;
        checkCars(tag);
        checkOutput({tag, " state"}, int'(game_state), v.st);
        checkOutput({tag, " lives"}, int'(lives), v.li);
        checkOutput({tag, " level"}, int'(level), v.lv);
        checkOutput({tag, " ticks"}, fTicks, v.ticks);
        checkOutput({tag, " resets"}, fResets, v.resets);
    endtask

    task automatic applyStimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        fTicks  = 0;
        fResets = 0;
        if (v.doStart != 0) pulseStart();
        if (v.reps == 0) checkRow(idx, v);
        for (int r = 0; r < v.reps; r++) begin
            if (r > 0) begin
                fTicks  = 0;
                fResets = 0;
            end
            runFrame(v.px, v.py);
            checkRow(idx, v);
        end
    endtask

    initial begin
        h_count  = 10'd5;
        v_count  = 10'd0;
        player_x = 10'd300;
        player_y = 10'd400;
        start    = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        mx[0] = 0; mx[1] = 160; mx[2] = 320; mx[3] = 480;
        checkCars("reset");
        checkOutput("reset state", int'(game_state), 0);
        checkOutput("reset lives", int'(lives), 3);
        checkOutput("reset level", int'(level), 0);
        checkOutput("reset player_reset", int'(player_reset), 0);
        checkOutput("reset frame_tick", int'(frame_tick), 0);
        RST_N = 1'b1;

        vecs[0]  = mk(0, 1,  300, 400,   0, 160, 320, 480, 0, 3, 0, 1, 0);
        vecs[1]  = mk(0, 1,  300, 400,   0, 160, 320, 480, 0, 3, 0, 1, 0);
        vecs[2]  = mk(1, 0,  300, 400,   0, 160, 320, 480, 1, 3, 0, 0, 0);
        vecs[3]  = mk(0, 1,  300, 400,   1, 158, 321, 478, 1, 3, 0, 1, 0);
        vecs[4]  = mk(0, 1,  170, 165,   2, 156, 322, 476, 2, 2, 0, 1, 0);
        vecs[5]  = mk(0, 59, 300, 400,   2, 156, 322, 476, 2, 2, 0, 1, 0);
        vecs[6]  = mk(0, 1,  300, 400,   2, 156, 322, 476, 1, 2, 0, 1, 1);
        vecs[7]  = mk(0, 1,  300, 400,   3, 154, 323, 474, 1, 2, 0, 1, 0);
        vecs[8]  = mk(0, 1,  300, 30,    4, 152, 324, 472, 1, 2, 1, 1, 1);
        vecs[9]  = mk(0, 1,  300, 400,   6, 149, 326, 469, 1, 2, 1, 1, 0);
        vecs[10] = mk(0, 1,  20,  30,    8, 146, 328, 466, 2, 1, 1, 1, 0);
        vecs[11] = mk(0, 59, 300, 400,   8, 146, 328, 466, 2, 1, 1, 1, 0);
        vecs[12] = mk(0, 1,  300, 400,   8, 146, 328, 466, 1, 1, 1, 1, 1);
        vecs[13] = mk(0, 1,  150, 165,  10, 143, 330, 463, 3, 0, 1, 1, 0);
        vecs[14] = mk(0, 3,  300, 400,  10, 143, 330, 463, 3, 0, 1, 1, 0);
        vecs[15] = mk(1, 0,  300, 400,   0, 160, 320, 480, 1, 3, 0, 0, 1);
        vecs[16] = mk(1, 1,  300, 400,   1, 158, 321, 478, 1, 3, 0, 1, 0);

        for (int i = 0; i < 17; i++) applyStimulus(i);

        // Level 0 after restart: run through every lane wrap until the cars realign.
        for (int n = 2; n <= 640; n++) begin
            fTicks  = 0;
            fResets = 0;
            runFrame(300, 400);
            mx[0] = (0 + n) % 640;
            mx[1] = wrapL(160, 2 * n);
            mx[2] = (320 + n) % 640;
            mx[3] = wrapL(480, 2 * n);
            checkCars($sformatf("wrap n=%0d", n));
        end

        // Nine crossings: level saturates at 7, each reset lands 7 cycles after the tick.
        mx[0] = 0; mx[1] = 160; mx[2] = 320; mx[3] = 480;
        lvl = 0;
        for (int k = 1; k <= 9; k++) begin
            int px;
            mx[0] = wrapR(mx[0], 1 + lvl);
            mx[1] = wrapL(mx[1], 2 + lvl);
            mx[2] = wrapR(mx[2], 1 + lvl);
            mx[3] = wrapL(mx[3], 2 + lvl);
            px = (mx[0] < 500) ? mx[0] + 100 : mx[0] - 100;
            fTicks    = 0;
            fResets   = 0;
            fResetOff = -1;
            runFrame(px, 30);
            lvl = (lvl < 7) ? lvl + 1 : 7;
            checkCars($sformatf("goal k=%0d", k));
            checkOutput($sformatf("goal k=%0d level", k), int'(level), lvl);
            checkOutput($sformatf("goal k=%0d resets", k), fResets, 1);
            checkOutput($sformatf("goal k=%0d reset offset", k), fResetOff, 7);
            checkOutput($sformatf("goal k=%0d state", k), int'(game_state), 1);
        end

        mx[0] = wrapR(mx[0], 8);
        mx[1] = wrapL(mx[1], 9);
        mx[2] = wrapR(mx[2], 8);
        mx[3] = wrapL(mx[3], 9);
        fTicks  = 0;
        fResets = 0;
        runFrame(300, 400);
        checkCars("level7 speed");
        checkOutput("level7 level", int'(level), 7);
        checkOutput("level7 resets", fResets, 0);

        // Reset asserted in the middle of a scan that would otherwise register a hit.
        mx[1] = wrapL(mx[1], 9);
        @(posedge CLK); #1;
        h_count  = 10'd0;
        v_count  = 10'd480;
        player_x = 10'(mx[1]);
        player_y = 10'd165;
        for (int c = 1; c < 3; c++) begin
            @(posedge CLK); #1;
            h_count = 10'd5;
            v_count = 10'd0;
        end
        checkOutput("pre-reset car_x2", int'(car_x2), mx[1]);
        @(posedge CLK); #1;
        RST_N = 1'b0;
        #1;
        mx[0] = 0; mx[1] = 160; mx[2] = 320; mx[3] = 480;
        checkCars("midscan");
        checkOutput("midscan state", int'(game_state), 0);
        checkOutput("midscan lives", int'(lives), 3);
        checkOutput("midscan level", int'(level), 0);
        checkOutput("midscan player_reset", int'(player_reset), 0);
        checkOutput("midscan frame_tick", int'(frame_tick), 0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N   = 1'b1;
        fResets = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge CLK); #1;
            if (player_reset) fResets++;
        end
        checkOutput("post-reset resets", fResets, 0);
        checkOutput("post-reset state", int'(game_state), 0);
        checkOutput("post-reset lives", int'(lives), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
